// File: rtl/inside_set_q.sv
// Ordered element queue with push, pop, and a registered "is value inside the set" query.
// Optionally drops duplicate pushes. Supports an override of the reported hit flag.
module inside_set_q #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int INIT_COUNT = 2,
  parameter int ALLOW_DUP  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     pop_ok,
  input  logic                     query_valid,
  input  logic [WIDTH-1:0]         query_data,
  output logic                     hit_valid,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic                     dup_drop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  input  logic                     ovr_en,
  input  logic                     ovr_hit
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [WIDTH-1:0] mem_r       [DEPTH];
  logic [WIDTH-1:0] mem_shift_s [DEPTH];
  logic [WIDTH-1:0] mem_nxt_s   [DEPTH];
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic [CW-1:0]    wr_idx_s;

  logic [DEPTH-1:0] live_s;
  logic [DEPTH-1:0] push_match_vec_s;
  logic [DEPTH-1:0] query_match_vec_s;
  logic             full_s;
  logic             empty_s;
  logic             ready_s;
  logic             pop_do_s;
  logic             push_acc_s;
  logic             dup_s;
  logic             push_do_s;
  logic             q_any_s;
  logic [IW-1:0]    q_idx_s;

  logic [WIDTH-1:0] pop_data_r;
  logic             pop_ok_r;
  logic             hit_valid_r;
  logic             hit_r;
  logic [IW-1:0]    hit_idx_r;
  logic             dup_drop_r;

  assign full_s     = (count_r == CW'(DEPTH));
  assign empty_s    = (count_r == {CW{1'b0}});
  assign ready_s    = !full_s | (pop_req & !empty_s);
  assign pop_do_s   = pop_req & !empty_s;
  assign push_acc_s = push_valid & ready_s;
  assign dup_s      = (ALLOW_DUP == 0) ? (push_acc_s & (|push_match_vec_s)) : 1'b0;
  assign push_do_s  = push_acc_s & !dup_s;
  assign wr_idx_s   = count_r - CW'(pop_do_s);
  assign count_nxt_s = count_r + CW'(push_do_s) - CW'(pop_do_s);

  // Compare against live (index < count) entries only; lowest index wins.
  always_comb begin
    live_s            = '0;
    push_match_vec_s  = '0;
    query_match_vec_s = '0;
    q_idx_s           = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_s[i]            = (CW'(i) < count_r);
      push_match_vec_s[i]  = live_s[i] && (mem_r[i] == push_data);
      query_match_vec_s[i] = live_s[i] && (mem_r[i] == query_data);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      q_idx_s = query_match_vec_s[i] ? IW'(i) : q_idx_s;
    end
    q_any_s = |query_match_vec_s;
  end

  // Next contents: optional shift-down for a pop, then write the push at the new back.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      mem_shift_s[i] = pop_do_s ? mem_r[i+1] : mem_r[i];
    end
    mem_shift_s[DEPTH-1] = mem_r[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push_do_s && (CW'(i) == wr_idx_s)) begin
        mem_nxt_s[i] = push_data;
      end else begin
        mem_nxt_s[i] = mem_shift_s[i];
      end
    end
  end

  // Storage, count and registered result outputs; reset reloads the preload pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= (i < INIT_COUNT) ? WIDTH'(i) : {WIDTH{1'b0}};
      end
      count_r     <= CW'(INIT_COUNT);
      pop_data_r  <= {WIDTH{1'b0}};
      pop_ok_r    <= 1'b0;
      hit_valid_r <= 1'b0;
      hit_r       <= 1'b0;
      hit_idx_r   <= {IW{1'b0}};
      dup_drop_r  <= 1'b0;
    end else begin
      mem_r       <= mem_nxt_s;
      count_r     <= count_nxt_s;
      pop_ok_r    <= pop_do_s;
      pop_data_r  <= pop_do_s ? mem_r[0] : pop_data_r;
      dup_drop_r  <= dup_s;
      hit_valid_r <= query_valid;
      if (query_valid) begin
        hit_r     <= ovr_en ? ovr_hit : q_any_s;
        hit_idx_r <= q_idx_s;
      end else begin
        hit_r     <= hit_r;
        hit_idx_r <= hit_idx_r;
      end
    end
  end

  assign push_ready = ready_s;
  assign full       = full_s;
  assign empty      = empty_s;
  assign count      = count_r;
  assign pop_data   = pop_data_r;
  assign pop_ok     = pop_ok_r;
  assign hit_valid  = hit_valid_r;
  assign hit        = hit_r;
  assign hit_idx    = hit_idx_r;
  assign dup_drop   = dup_drop_r;

endmodule

// File: tb/tb_inside_set_q.sv
// Bench for inside_set_q: two instances (duplicates allowed / filtered) share stimulus
// and are checked every cycle against a list-based reference model.
module tb_inside_set_q;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_valid, pop_req, query_valid, ovr_en, ovr_hit;
  logic [7:0] push_data, query_data;

  logic       push_ready [2];
  logic [7:0] pop_data   [2];
  logic       pop_ok     [2];
  logic       hit_valid  [2];
  logic       hit        [2];
  logic [2:0] hit_idx    [2];
  logic       dup_drop   [2];
  logic [3:0] count      [2];
  logic       full       [2];
  logic       empty      [2];

  always #5 clk = ~clk;

  inside_set_q #(.WIDTH(8), .DEPTH(8), .INIT_COUNT(2), .ALLOW_DUP(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready[0]),
    .pop_req(pop_req), .pop_data(pop_data[0]), .pop_ok(pop_ok[0]),
    .query_valid(query_valid), .query_data(query_data),
    .hit_valid(hit_valid[0]), .hit(hit[0]), .hit_idx(hit_idx[0]),
    .dup_drop(dup_drop[0]), .count(count[0]), .full(full[0]), .empty(empty[0]),
    .ovr_en(ovr_en), .ovr_hit(ovr_hit)
  );

  inside_set_q #(.WIDTH(8), .DEPTH(8), .INIT_COUNT(2), .ALLOW_DUP(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready[1]),
    .pop_req(pop_req), .pop_data(pop_data[1]), .pop_ok(pop_ok[1]),
    .query_valid(query_valid), .query_data(query_data),
    .hit_valid(hit_valid[1]), .hit(hit[1]), .hit_idx(hit_idx[1]),
    .dup_drop(dup_drop[1]), .count(count[1]), .full(full[1]), .empty(empty[1]),
    .ovr_en(ovr_en), .ovr_hit(ovr_hit)
  );

  // Reference model: a plain list per instance plus the expected registered outputs.
  int         mcnt  [2];
  logic [7:0] mlist [2][8];
  logic       e_pok [2];
  logic       e_hv  [2];
  logic       e_hit [2];
  logic       e_dup [2];
  logic [7:0] e_pd  [2];
  int         e_idx [2];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[dut%0d] actual=%0d expected=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 2;
      for (int i = 0; i < 8; i++) mlist[k][i] = (i < 2) ? 8'(i) : 8'd0;
      e_pok[k] = 1'b0; e_hv[k] = 1'b0; e_hit[k] = 1'b0; e_dup[k] = 1'b0;
      e_pd[k] = 8'd0; e_idx[k] = 0;
    end
  endtask

  task automatic check_regs(input int k);
    check("pop_ok", k, 32'(pop_ok[k]), 32'(e_pok[k]));
    check("pop_data", k, 32'(pop_data[k]), 32'(e_pd[k]));
    check("hit_valid", k, 32'(hit_valid[k]), 32'(e_hv[k]));
    check("dup_drop", k, 32'(dup_drop[k]), 32'(e_dup[k]));
    check("count", k, 32'(count[k]), mcnt[k]);
    if (e_hv[k]) begin
      check("hit", k, 32'(hit[k]), 32'(e_hit[k]));
      check("hit_idx", k, 32'(hit_idx[k]), e_idx[k]);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge, check registers.
  task automatic step(input logic pv, input logic [7:0] pd, input logic pr,
                      input logic qv, input logic [7:0] qd, input logic oe, input logic oh);
    bit rdy [2];
    bit popdo, acc, isdup;
    int found;
    push_valid = pv; push_data = pd; pop_req = pr;
    query_valid = qv; query_data = qd; ovr_en = oe; ovr_hit = oh;
    #1;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = (mcnt[k] < 8) || (pr && mcnt[k] > 0);
      check("push_ready", k, 32'(push_ready[k]), 32'(rdy[k]));
      check("full", k, 32'(full[k]), 32'(mcnt[k] == 8));
      check("empty", k, 32'(empty[k]), 32'(mcnt[k] == 0));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      popdo = pr && (mcnt[k] > 0);
      acc   = pv && rdy[k];
      isdup = 1'b0;
      found = -1;
      for (int i = 0; i < mcnt[k]; i++) begin
        if (k == 1 && acc && mlist[k][i] == pd) isdup = 1'b1;
        if (found < 0 && mlist[k][i] == qd) found = i;
      end
      e_hv[k] = qv;
      if (qv) begin
        e_hit[k] = oe ? oh : (found >= 0);
        e_idx[k] = (found >= 0) ? found : 0;
      end
      e_pok[k] = popdo;
      if (popdo) e_pd[k] = mlist[k][0];
      e_dup[k] = isdup;
      if (popdo) begin
        for (int i = 0; i < mcnt[k] - 1; i++) mlist[k][i] = mlist[k][i+1];
        mcnt[k]--;
      end
      if (acc && !isdup) begin
        mlist[k][mcnt[k]] = pd;
        mcnt[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) check_regs(k);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    push_valid = 1'b0; pop_req = 1'b0; query_valid = 1'b0; ovr_en = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) check_regs(k);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int drain_exp [8] = '{1, 2, 3, 4, 5, 6, 7, 9};

  initial begin
    push_valid = 1'b0; push_data = 8'd0; pop_req = 1'b0;
    query_valid = 1'b0; query_data = 8'd0; ovr_en = 1'b0; ovr_hit = 1'b0;
    @(negedge clk);
    do_reset();

    // Preloaded contents 0,1
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    check("lit_q1_hv", 0, 32'(hit_valid[0]), 1);
    check("lit_q1_hit", 0, 32'(hit[0]), 1);
    check("lit_q1_idx", 0, 32'(hit_idx[0]), 1);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    check("lit_q5_hit", 0, 32'(hit[0]), 0);
    check("lit_cnt2", 0, 32'(count[0]), 2);

    // Fill to full, then overflow with and without a pop
    for (int v = 2; v < 8; v++) step(1'b1, 8'(v), 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("lit_full", 0, 32'(full[0]), 1);
    check("lit_cnt8", 0, 32'(count[0]), 8);
    check("lit_ready_full", 0, 32'(push_ready[0]), 0);
    step(1'b1, 8'd9, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("lit_ovf_cnt", 0, 32'(count[0]), 8);
    step(1'b1, 8'd9, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check("lit_pp_data", 0, 32'(pop_data[0]), 0);
    check("lit_pp_ok", 0, 32'(pop_ok[0]), 1);
    check("lit_pp_cnt", 0, 32'(count[0]), 8);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0);
    check("lit_q9_idx", 0, 32'(hit_idx[0]), 7);

    // Drain in push order, then pop on empty
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
      check("lit_drain", 0, 32'(pop_data[0]), drain_exp[i]);
    end
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    check("lit_empty_pok", 0, 32'(pop_ok[0]), 0);
    check("lit_empty", 0, 32'(empty[0]), 1);

    // Duplicate filtering
    do_reset();
    step(1'b1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("lit_dup1", 1, 32'(dup_drop[1]), 1);
    check("lit_dup1_cnt", 1, 32'(count[1]), 2);
    check("lit_nodup_cnt", 0, 32'(count[0]), 3);
    step(1'b1, 8'd4, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    check("lit_dup4", 1, 32'(dup_drop[1]), 0);
    check("lit_dup4_cnt", 1, 32'(count[1]), 3);

    // Stale storage beyond count never matches
    do_reset();
    step(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    check("lit_stale_hit", 0, 32'(hit[0]), 0);

    // Override
    do_reset();
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0);
    check("lit_ovr_hit", 0, 32'(hit[0]), 0);
    check("lit_ovr_idx", 0, 32'(hit_idx[0]), 0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    check("lit_noovr_hit", 0, 32'(hit[0]), 1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end

    // Reset with a pop and query in flight
    step(1'b1, 8'd7, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    pop_req = 1'b1; query_valid = 1'b1; query_data = 8'd0; push_valid = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check("lit_rst_cnt", 0, 32'(count[0]), 2);
    step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    check("lit_rst_q1", 0, 32'(hit_idx[0]), 1);
    step(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    check("lit_rst_q0", 0, 32'(hit[0]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
